// File: rtl/poly1305_pkg.sv
// Shared Poly1305 definitions: sequencer state encoding and datapath widths.
package poly1305_pkg;
    localparam int ACC_WIDTH   = 130;
    localparam int BLOCK_BYTES = 16;
    localparam int KEY_WIDTH   = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ABSORB = 2'd1,
        FINAL  = 2'd2,
        DONE   = 2'd3
    } seq_state_t;
endpackage

// File: rtl/poly1305_block.sv
// Combinational Poly1305 block step: acc_out = ((acc + pad(block)) * r) mod (2^130 - 5), fully reduced.
module poly1305_block
    import poly1305_pkg::*;
(
    input  logic [8*BLOCK_BYTES-1:0] i_data,
    input  logic [3:0]               i_bytes_minus_one,
    input  logic [ACC_WIDTH-1:0]     i_acc,
    input  logic [127:0]             i_r,
    output logic [ACC_WIDTH-1:0]     o_acc
);
    localparam logic [ACC_WIDTH-1:0] P_MOD = 130'h3_ffffffff_ffffffff_ffffffff_fffffffb;

    logic [4:0]   w_len;
    logic [7:0]   w_shift;
    logic [128:0] w_mask;
    logic [128:0] w_msg;
    logic [130:0] w_sum;
    logic [258:0] w_prod;
    logic [132:0] w_hi1;
    logic [132:0] w_fold1;
    logic [130:0] w_hi2;
    logic [130:0] w_fold2;
    logic         w_ge_p;

    // Keep only the valid bytes and append the 0x01 pad byte right after them.
    assign w_len   = {1'b0, i_bytes_minus_one} + 5'd1;
    assign w_shift = {w_len, 3'b000};
    assign w_mask  = (129'd1 << w_shift) - 129'd1;
    assign w_msg   = ({1'b0, i_data} & w_mask) | (129'd1 << w_shift);

    assign w_sum  = {1'b0, i_acc} + {2'b00, w_msg};
    assign w_prod = {128'd0, w_sum} * {131'd0, i_r};

    // 2^130 == 5 (mod p): fold the high part back in twice, then one conditional subtract.
    assign w_hi1   = {4'd0, w_prod[258:130]};
    assign w_fold1 = {3'd0, w_prod[129:0]} + (w_hi1 << 2) + w_hi1;
    assign w_hi2   = {128'd0, w_fold1[132:130]};
    assign w_fold2 = {1'b0, w_fold1[129:0]} + (w_hi2 << 2) + w_hi2;
    assign w_ge_p  = w_fold2 >= {1'b0, P_MOD};
    assign o_acc   = w_ge_p ? (w_fold2[129:0] - P_MOD) : w_fold2[129:0];
endmodule

// File: rtl/poly1305_clamp.sv
// Poly1305 r clamp: clears the top nibble of bytes 3/7/11/15 and the low two bits of bytes 4/8/12.
module poly1305_clamp (
    input  logic [127:0] i_r,
    output logic [127:0] o_r
);
    localparam logic [127:0] CLAMP_MASK = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;

    assign o_r = i_r & CLAMP_MASK;
endmodule

// File: rtl/poly1305_seq_fsm.sv
// Poly1305 sequencer control: state register plus key/block/tag handshake decode.
module poly1305_seq_fsm
    import poly1305_pkg::*;
(
    input  logic i_clock,
    input  logic i_clear,
    input  logic i_key_valid,
    input  logic i_key_msg_empty,
    input  logic i_in_valid,
    input  logic i_in_last,
    input  logic i_tag_ready,
    output logic o_key_ready,
    output logic o_in_ready,
    output logic o_tag_valid,
    output logic o_busy,
    output logic o_key_load,
    output logic o_block_load,
    output logic o_tag_load,
    output logic o_tag_take
);
    seq_state_t r_state;
    seq_state_t w_next;

    always_ff @(posedge i_clock or posedge i_clear) begin
        if (i_clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_key_valid) w_next = i_key_msg_empty ? FINAL : ABSORB;
            ABSORB:  if (i_in_valid && i_in_last) w_next = FINAL;
            FINAL:   w_next = DONE;
            DONE:    if (i_tag_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_key_ready  = (r_state == IDLE);
        o_in_ready   = (r_state == ABSORB);
        o_tag_valid  = (r_state == DONE);
        o_busy       = (r_state != IDLE);
        o_key_load   = (r_state == IDLE) && i_key_valid;
        o_block_load = (r_state == ABSORB) && i_in_valid;
        o_tag_load   = (r_state == FINAL);
        o_tag_take   = (r_state == DONE) && i_tag_ready;
    end
endmodule

// File: rtl/poly1305_message_sequencer.sv
// Sequences one Poly1305 MAC over a stream of 16-byte blocks and presents tag = acc + s.
// Define POLY1305_SEQ_ZEROIZE_EN to wipe r, s, acc and tag on the tag handshake.
module poly1305_message_sequencer
    import poly1305_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     key_valid,
    output logic                     key_ready,
    input  logic [KEY_WIDTH-1:0]     key,
    input  logic                     key_msg_empty,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*BLOCK_BYTES-1:0] in_data,
    input  logic [3:0]               in_bytes_minus_one,
    input  logic                     in_last,
    output logic                     tag_valid,
    input  logic                     tag_ready,
    output logic [127:0]             tag,
    output logic                     busy,
    output logic [COUNT_WIDTH-1:0]   block_count,
    output logic                     count_overflow
);
`ifdef POLY1305_SEQ_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    logic [127:0]           r_r;
    logic [127:0]           r_s;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [127:0]           r_tag;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_ovf;

    logic [127:0]           w_r_clamped;
    logic [ACC_WIDTH-1:0]   w_acc_next;
    logic                   w_key_load;
    logic                   w_block_load;
    logic                   w_tag_load;
    logic                   w_tag_take;

    poly1305_seq_fsm u_fsm (
        .i_clock         (clock),
        .i_clear         (clear),
        .i_key_valid     (key_valid),
        .i_key_msg_empty (key_msg_empty),
        .i_in_valid      (in_valid),
        .i_in_last       (in_last),
        .i_tag_ready     (tag_ready),
        .o_key_ready     (key_ready),
        .o_in_ready      (in_ready),
        .o_tag_valid     (tag_valid),
        .o_busy          (busy),
        .o_key_load      (w_key_load),
        .o_block_load    (w_block_load),
        .o_tag_load      (w_tag_load),
        .o_tag_take      (w_tag_take)
    );

    poly1305_clamp u_clamp (
        .i_r (key[127:0]),
        .o_r (w_r_clamped)
    );

    poly1305_block u_block (
        .i_data            (in_data),
        .i_bytes_minus_one (in_bytes_minus_one),
        .i_acc             (r_acc),
        .i_r               (r_r),
        .o_acc             (w_acc_next)
    );

    // The load strobes come from distinct states, so at most one is active per cycle.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_r     <= '0;
            r_s     <= '0;
            r_acc   <= '0;
            r_tag   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_key_load) begin
                r_r     <= w_r_clamped;
                r_s     <= key[KEY_WIDTH-1:128];
                r_acc   <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end
            if (w_block_load) begin
                r_acc   <= w_acc_next;
                r_count <= r_count + COUNT_WIDTH'(1);
                if (&r_count) r_ovf <= 1'b1;
            end
            if (w_tag_load) begin
                r_tag <= r_acc[127:0] + r_s;
            end
            if (ZEROIZE && w_tag_take) begin
                r_r   <= '0;
                r_s   <= '0;
                r_acc <= '0;
                r_tag <= '0;
            end
        end
    end

    assign tag            = r_tag;
    assign block_count    = r_count;
    assign count_overflow = r_ovf;
endmodule

// File: tb/tb_poly1305_message_sequencer.sv
// Scoreboard bench for poly1305_message_sequencer: RFC 8439 vector, empty message, backpressure,
// mid-message clear, block counter wrap and random messages; follows POLY1305_SEQ_ZEROIZE_EN.
module tb_poly1305_message_sequencer;
    localparam int COUNT_W = 2;
    localparam logic [129:0] P_MOD   = 130'h3_ffffffff_ffffffff_ffffffff_fffffffb;
    localparam logic [255:0] RFC_KEY = 256'h1bf54941aff6bf4afdb20dfb8a800301_a806d542fe52447f336d555778bed685;
    localparam logic [127:0] RFC_TAG = 128'ha927010caf8b2bc2c6365130c11d06a8;

    typedef struct {
        logic [127:0] tag;
        int           count;
        bit           ovf;
        int           cycle;
    } expEntry_t;

    logic               clock;
    logic               clear;
    logic               key_valid;
    logic               key_ready;
    logic [255:0]       key;
    logic               key_msg_empty;
    logic               in_valid;
    logic               in_ready;
    logic [127:0]       in_data;
    logic [3:0]         in_bytes_minus_one;
    logic               in_last;
    logic               tag_valid;
    logic               tag_ready;
    logic [127:0]       tag;
    logic               busy;
    logic [COUNT_W-1:0] block_count;
    logic               count_overflow;

    int           checks = 0;
    int           errors = 0;
    int           cycleCount = 0;
    expEntry_t    expQ[$];
    logic [127:0] msgData[$];
    int           msgLen[$];
    logic [127:0] lastExpTag;

    poly1305_message_sequencer #(.COUNT_WIDTH(COUNT_W)) dut (
        .clock              (clock),
        .clear              (clear),
        .key_valid          (key_valid),
        .key_ready          (key_ready),
        .key                (key),
        .key_msg_empty      (key_msg_empty),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_data            (in_data),
        .in_bytes_minus_one (in_bytes_minus_one),
        .in_last            (in_last),
        .tag_valid          (tag_valid),
        .tag_ready          (tag_ready),
        .tag                (tag),
        .busy               (busy),
        .block_count        (block_count),
        .count_overflow     (count_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cycleCount <= cycleCount + 1;

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: time limit reached, expected the run to complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [255:0] randWide();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    // Reference model: RFC 8439 Poly1305 evaluated with plain big-number arithmetic.
    function automatic logic [127:0] clampR(input logic [127:0] r);
        logic [127:0] c;
        c = r;
        for (int i = 3; i < 16; i += 4) c[8*i +: 8] = c[8*i +: 8] & 8'h0f;
        for (int i = 4; i < 16; i += 4) c[8*i +: 8] = c[8*i +: 8] & 8'hfc;
        return c;
    endfunction

    function automatic logic [127:0] modelTag(input logic [255:0] k);
        logic [258:0] acc;
        logic [258:0] rr;
        logic [258:0] n;
        logic [258:0] p;
        logic [127:0] blk;
        p   = {129'd0, P_MOD};
        rr  = {131'd0, clampR(k[127:0])};
        acc = '0;
        for (int i = 0; i < msgData.size(); i++) begin
            blk = msgData[i];
            n   = '0;
            for (int b = 0; b <= msgLen[i]; b++) n[8*b +: 8] = blk[8*b +: 8];
            n[8*(msgLen[i]+1)] = 1'b1;
            acc = ((acc + n) * rr) % p;
        end
        return acc[127:0] + k[255:128];
    endfunction

    task automatic loadRfc();
        string        s;
        logic [255:0] junk;
        logic [127:0] d;
        int           len;
        s = "Cryptographic Forum Research Group";
        msgData.delete();
        msgLen.delete();
        for (int blk = 0; blk < 3; blk++) begin
            junk = randWide();
            d    = junk[127:0];
            len  = (blk == 2) ? 2 : 16;
            for (int b = 0; b < len; b++) d[8*b +: 8] = s[16*blk + b];
            msgData.push_back(d);
            msgLen.push_back(len - 1);
        end
    endtask

    task automatic fillRandom(input int n, input bit varyLen);
        logic [255:0] junk;
        msgData.delete();
        msgLen.delete();
        for (int i = 0; i < n; i++) begin
            junk = randWide();
            msgData.push_back(junk[127:0]);
            msgLen.push_back((varyLen && $urandom_range(3, 0) == 0) ? int'($urandom_range(14, 0)) : 15);
        end
    endtask

    task automatic checkResetState(input string pfx);
        checkOutput({pfx, "_key_ready"}, key_ready, 1);
        checkOutput({pfx, "_in_ready"}, in_ready, 0);
        checkOutput({pfx, "_tag_valid"}, tag_valid, 0);
        checkOutput({pfx, "_tag"}, tag, 0);
        checkOutput({pfx, "_busy"}, busy, 0);
        checkOutput({pfx, "_block_count"}, block_count, 0);
        checkOutput({pfx, "_count_overflow"}, count_overflow, 0);
    endtask

    task automatic applyKey(input logic [255:0] k, input bit empty, output int c);
        int w;
        w = 0;
        @(negedge clock);
        key = k;
        key_msg_empty = empty;
        key_valid = 1'b1;
        while (!key_ready && w < 100) begin
            @(negedge clock);
            w++;
        end
        if (!key_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL key_handshake_timeout: key_ready %0b, expected 1", key_ready);
            key_valid = 1'b0;
            c = 0;
            return;
        end
        c = cycleCount;
        @(posedge clock);
        #1 key_valid = 1'b0;
    endtask

    // Gap cycles carry junk key offers, which must be ignored while absorbing.
    task automatic sendBlock(input int idx, input bit last, input int gapMax, output int c);
        int           g;
        int           w;
        logic [255:0] junk;
        w = 0;
        g = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
        repeat (g) begin
            @(negedge clock);
            junk      = randWide();
            in_valid  = 1'b0;
            key_valid = 1'($urandom_range(1, 0));
            key       = junk;
            in_data   = junk[255:128];
        end
        @(negedge clock);
        key_valid          = 1'b0;
        in_valid           = 1'b1;
        in_data            = msgData[idx];
        in_bytes_minus_one = 4'(msgLen[idx]);
        in_last            = last;
        while (!in_ready && w < 100) begin
            @(negedge clock);
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL block_handshake_timeout: in_ready %0b, expected 1", in_ready);
            in_valid = 1'b0;
            c = 0;
            return;
        end
        c = cycleCount;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Stall cycles carry junk block offers, which must be ignored while the tag is held.
    task automatic takeTag(input int stall, input bit overlap);
        int           w;
        logic [255:0] junk;
        w = 0;
        @(negedge clock);
        while (!tag_valid && w < 100) begin
            @(negedge clock);
            w++;
        end
        if (!tag_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL tag_timeout: tag_valid %0b, expected 1", tag_valid);
            return;
        end
        repeat (stall) begin
            junk     = randWide();
            in_valid = 1'b1;
            in_data  = junk[127:0];
            in_last  = 1'($urandom_range(1, 0));
            @(negedge clock);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        tag_ready = 1'b1;
        if (overlap) begin
            key           = randWide();
            key_msg_empty = 1'b1;
            key_valid     = 1'b1;
        end
        @(posedge clock);
        #1 tag_ready = 1'b0;
        @(negedge clock);
        checkOutput("tag_valid_after_take", tag_valid, 0);
        checkOutput("key_ready_after_take", key_ready, 1);
`ifdef POLY1305_SEQ_ZEROIZE_EN
        checkOutput("tag_zeroized", tag, 0);
        checkOutput("r_zeroized", dut.r_r, 0);
        checkOutput("s_zeroized", dut.r_s, 0);
        checkOutput("acc_zeroized", dut.r_acc, 0);
`else
        checkOutput("tag_retained", tag, lastExpTag);
`endif
        key_valid     = 1'b0;
        key_msg_empty = 1'b0;
    endtask

    task automatic applyStimulus(input logic [255:0] k, input logic [127:0] expTag,
                                 input int gapMax, input int stall, input bit overlap);
        int        n;
        int        c;
        expEntry_t e;
        n = msgData.size();
        applyKey(k, n == 0, c);
        for (int i = 0; i < n; i++) sendBlock(i, i == n - 1, gapMax, c);
        e.tag   = expTag;
        e.count = n % (1 << COUNT_W);
        e.ovf   = (n >= (1 << COUNT_W));
        e.cycle = c + 2;
        expQ.push_back(e);
        lastExpTag = expTag;
        takeTag(stall, overlap);
    endtask

    // Monitor: pops one expectation per tag presentation, and checks the tag is held while stalled.
    initial begin : monitor
        bit           prevValid;
        logic [127:0] heldTag;
        expEntry_t    e;
        prevValid = 1'b0;
        heldTag   = '0;
        forever begin
            @(negedge clock);
            if (tag_valid && !prevValid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_tag: got tag %0h, expected no tag", tag);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("tag_value", tag, e.tag);
                    checkOutput("block_count", block_count, e.count);
                    checkOutput("count_overflow", count_overflow, e.ovf);
                    checkOutput("tag_latency_cycle", cycleCount, e.cycle);
                end
            end else if (tag_valid) begin
                checkOutput("tag_stable", tag, heldTag);
                checkOutput("key_ready_in_done", key_ready, 0);
                checkOutput("busy_in_done", busy, 1);
            end
            prevValid = tag_valid;
            heldTag   = tag;
        end
    end

    initial begin
        logic [255:0] k;
        int           c;
        clear              = 1'b1;
        key_valid          = 1'b0;
        key                = '0;
        key_msg_empty      = 1'b0;
        in_valid           = 1'b0;
        in_data            = '0;
        in_bytes_minus_one = '0;
        in_last            = 1'b0;
        tag_ready          = 1'b0;
        lastExpTag         = '0;
        repeat (2) @(negedge clock);
        checkResetState("reset");
        clear = 1'b0;

        loadRfc();
        applyStimulus(RFC_KEY, RFC_TAG, 0, 0, 1'b0);

        k = randWide();
        k[255:128] = 128'h0123456789abcdef0123456789abcdef;
        msgData.delete();
        msgLen.delete();
        applyStimulus(k, 128'h0123456789abcdef0123456789abcdef, 0, 3, 1'b1);

        loadRfc();
        applyStimulus(RFC_KEY, RFC_TAG, 3, 10, 1'b0);

        loadRfc();
        applyKey(RFC_KEY, 1'b0, c);
        sendBlock(0, 1'b0, 0, c);
        sendBlock(1, 1'b0, 0, c);
        @(negedge clock);
        clear = 1'b1;
        #1 checkResetState("midclear");
        @(negedge clock);
        clear = 1'b0;
        repeat (3) @(negedge clock);
        loadRfc();
        applyStimulus(RFC_KEY, RFC_TAG, 1, 2, 1'b1);

        k = randWide();
        fillRandom(5, 1'b0);
        applyStimulus(k, modelTag(k), 0, 1, 1'b0);

        for (int m = 0; m < 12; m++) begin
            k = randWide();
            fillRandom($urandom_range(6, 0), 1'b1);
            applyStimulus(k, modelTag(k), $urandom_range(2, 0), $urandom_range(3, 0), 1'($urandom_range(1, 0)));
        end

        repeat (5) @(negedge clock);
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/poly1305_message_sequencer.md
Name: poly1305_message_sequencer

Overview:
Sequences one Poly1305 MAC computation over a message delivered as a stream of 16-byte blocks. Latches the one-time key, clamps r, and feeds each accepted block through the existing combinational poly1305_block with a locally held 130-bit accumulator. Adds s to form the tag and presents it on a valid/ready output. Sits between the ChaCha20 key-generation stage and the AEAD tag-compare/output logic.

Parameters:
COUNT_WIDTH, 32, width of the absorbed-block counter exported for debug/AAD-length checks

Ports:
clock  input  1  sole clock, rising edge
clear  input  1  reset, asynchronous, active-high
key_valid  input  1  key offer
key_ready  output  1  high only in IDLE
key  input  256  one-time key; r = key[127:0] (clamped internally), s = key[255:128]; byte 0 at key[7:0]
key_msg_empty  input  1  sampled with key; message has zero blocks
in_valid  input  1  block offer
in_ready  output  1  high only in ABSORB
in_data  input  128  block bytes, byte 0 at [7:0]; bytes above count ignored
in_bytes_minus_one  input  4  valid bytes in block minus one (0..15)
in_last  input  1  final block of message
tag_valid  output  1  tag available
tag_ready  input  1  tag consumer accept
tag  output  128  acc[127:0] + s, mod 2^128; held stable while tag_valid
busy  output  1  state != IDLE
block_count  output  COUNT_WIDTH  blocks absorbed in current message
count_overflow  output  1  sticky: block_count wrapped in current message

Behaviour:
- Reset (async, clear=1): state IDLE, acc=0, r=0, s=0, tag=0, tag_valid=0, block_count=0, count_overflow=0. Applies mid-message; no partial tag is ever emitted.
- States: IDLE, ABSORB, FINAL, DONE.
- IDLE: key_ready=1. On key_valid: latch clamp(key[127:0]) and key[255:128], acc<=0, block_count<=0, count_overflow<=0. Next state FINAL if key_msg_empty, else ABSORB.
- ABSORB: in_ready=1. On in_valid: acc <= poly1305_block(in_data, in_bytes_minus_one, acc, r), block_count+1. If in_last then next state FINAL. One block per cycle, no bubbles.
- in_bytes_minus_one<15 on a block without in_last: still absorbed as given (short non-final block is legal).
- FINAL: tag <= acc[127:0] + s (130-bit acc truncated, 128-bit wrapping add); next state DONE. Single cycle, no handshake.
- DONE: tag_valid=1. On tag_ready: tag_valid<=0, state IDLE. key_ready stays 0 until that transfer, so new key offered with tag_ready in the same cycle is accepted on the following cycle at the earliest.
- Latency: last-block handshake at cycle N -> tag_valid at N+2. Empty message: key handshake at N -> tag_valid at N+2, tag = s.
- block_count wraps at 2^COUNT_WIDTH; the wrap sets count_overflow (sticky until next key). Computation unaffected.
- Inputs on non-ready interfaces are ignored.

Optional Feature:
POLY1305_SEQ_ZEROIZE_EN
- Defined: on the tag handshake, r, s, acc, and tag are all cleared to 0 in the same edge. tag reads 0 whenever tag_valid=0.
- Undefined: these registers keep their values until the next key load. tag holds the last value after handshake.

Decomposition:
- Shared package poly1305_pkg: state enum (IDLE, ABSORB, FINAL, DONE), ACC_WIDTH=130, BLOCK_BYTES=16, KEY_WIDTH=256.
- Reuse the existing poly1305_clamp and poly1305_block.
- One new sub-module is natural: poly1305_seq_fsm (state register + handshake decode). Datapath registers stay in the top.

Test Plan:
- RFC 8439 §2.5.2: key 85d6be7857556d337f4452fe42d506a80103808afb0db2fd4abff6af4149f51b (byte 0 first), message "Cryptographic Forum Research Group" as blocks of 16, 16, and 2 (minus_one=15,15,1; last on third) -> tag bytes a8061dc1305136c6c22b8baf0c0127a9; tag_valid exactly 2 cycles after third handshake; block_count=3.
- key_msg_empty=1 with s=0x0123...ef -> tag=s two cycles later, block_count=0.
- Backpressure: hold tag_ready=0 for 10 cycles -> tag stable, key_ready=0 throughout. in_valid gaps mid-message -> same RFC tag.
- Assert clear after the second block of the RFC message -> outputs at reset values. Re-run the full message -> correct tag, no stale accumulator.
- COUNT_WIDTH=2, 5 blocks -> block_count=1, count_overflow=1, tag matches software model.
- With POLY1305_SEQ_ZEROIZE_EN defined, after tag handshake -> tag=0 and internal r/s/acc=0. Undefined -> tag retains its value.
